// File: rtl/noc_pkg.sv
// Shared NoC types: ring coordinates, message types, flit layout and ring routing.
package noc_pkg;

  localparam int unsigned kRingSize = 4;
  localparam int unsigned kXyWidth  = $clog2(kRingSize);

  typedef struct packed {
    logic [kXyWidth-1:0] x;
  } xy_t;

  typedef enum logic [2:0] {
    MsgReadReq,
    MsgReadResp,
    MsgWriteReq,
    MsgWriteResp,
    MsgInv,
    MsgInvAck,
    MsgFlush,
    MsgNop
  } message_t;

  // One-hot output port selection toward the router; all-zero means no flit.
  typedef enum logic [2:0] {
    DirNone = 3'b000,
    goLocal = 3'b001,
    goEast  = 3'b010,
    goWest  = 3'b100
  } direction_t;

  typedef struct packed {
    logic head;
    logic tail;
  } preamble_t;

  // Flit layout at the default 64-bit width: preamble in the top two bits.
  localparam int unsigned kFlitWidth = 64;

  typedef struct packed {
    preamble_t               preamble;
    logic [kFlitWidth-3:0]   payload;
  } flit_t;

  typedef enum logic [1:0] {
    StIdle,
    StHead,
    StBody
  } ni_state_t;

  // Shortest-way ring routing; a half-ring distance is sent East.
  function automatic direction_t ring_route(input xy_t dest, input xy_t here);
    int unsigned d;
    d = (32'(dest.x) + kRingSize - 32'(here.x)) % kRingSize;
    if (d == 0) begin
      return goLocal;
    end else if (d <= kRingSize / 2) begin
      return goEast;
    end
    return goWest;
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Tracks free downstream buffer slots: one consumed per issued flit, one
// returned per credit pulse.
module noc_credit_counter #(
  parameter int unsigned NumCredits = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic issue_i,
  input  logic credit_i,
  output logic avail_o
);

  localparam int unsigned CntW = $clog2(NumCredits + 1);
  localparam logic [CntW-1:0] Full = CntW'(NumCredits);

  logic [CntW-1:0] count_q, count_d;

  // Next count: simultaneous issue and return cancel; a return when full saturates.
  always_comb begin
    count_d = count_q;
    if (issue_i && !credit_i) begin
      count_d = count_q - 1'b1;
    end else if (credit_i && !issue_i && (count_q != Full)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register, full after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= Full;
    end else begin
      count_q <= count_d;
    end
  end

  assign avail_o = (count_q != '0);

  // A credit returned while every slot is already free is a downstream protocol error.
  credit_overflow_a : assert property (@(posedge clk_i) disable iff (rst_i)
      !(credit_i && !issue_i && (count_q == Full)))
    else $warning("noc_credit_counter: credit_in while counter full, saturating");

endmodule

// File: rtl/noc_packetizer.sv
// Network interface: turns a tile message header plus body words into a
// head flit and body flits, routed on the ring and paced by downstream credits.
module noc_packetizer
  import noc_pkg::*;
#(
  parameter int unsigned FlitWidth    = 64,
  parameter int unsigned MaxBodyFlits = 4,
  parameter int unsigned NumCredits   = 4,
  parameter xy_t         LocalX       = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              msg_valid_i,
  output logic                              msg_ready_o,
  input  xy_t                               msg_dest_i,
  input  message_t                          msg_type_i,
  input  logic [$clog2(MaxBodyFlits+1)-1:0] msg_len_i,
  input  logic                              data_valid_i,
  output logic                              data_ready_o,
  input  logic [FlitWidth-3:0]              data_word_i,
  output logic                              flit_valid_o,
  output logic [FlitWidth-1:0]              flit_data_o,
  output direction_t                        flit_dir_o,
  input  logic                              credit_in_i
);

  localparam int unsigned LenW     = $clog2(MaxBodyFlits + 1);
  localparam int unsigned PayloadW = FlitWidth - 2;
  // Head payload fields, packed from bit 0 upward.
  localparam int unsigned OffLocal = kXyWidth;
  localparam int unsigned OffType  = 2 * kXyWidth;
  localparam int unsigned OffLen   = OffType + $bits(message_t);

  typedef struct packed {
    preamble_t             preamble;
    logic [PayloadW-1:0]   payload;
  } flit_w_t;

  ni_state_t       state_q, state_d;
  xy_t             dest_q, dest_d;
  message_t        type_q, type_d;
  logic [LenW-1:0] len_q, len_d;
  logic [LenW-1:0] cnt_q, cnt_d, cnt_inc;
  direction_t      dir_q, dir_d;

  logic            issue;
  logic            credit_avail;
  flit_w_t         flit_d;

  logic            flit_valid_q;
  flit_w_t         flit_q;
  direction_t      flit_dir_q;

  noc_credit_counter #(
    .NumCredits(NumCredits)
  ) u_credits (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .issue_i (issue),
    .credit_i(credit_in_i),
    .avail_o (credit_avail)
  );

  // Message FSM: header capture, head flit, body flits; all outputs quiet in reset.
  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    type_d       = type_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    issue        = 1'b0;
    flit_d       = '0;
    msg_ready_o  = 1'b0;
    data_ready_o = 1'b0;
    cnt_inc      = cnt_q + 1'b1;

    if (!rst_i) begin
      unique case (state_q)
        StIdle: begin
          msg_ready_o = 1'b1;
          if (msg_valid_i) begin
            dest_d  = msg_dest_i;
            type_d  = msg_type_i;
            len_d   = msg_len_i;
            dir_d   = ring_route(msg_dest_i, LocalX);
            cnt_d   = '0;
            state_d = StHead;
          end
        end
        StHead: begin
          if (credit_avail) begin
            issue                                       = 1'b1;
            flit_d.preamble.head                        = 1'b1;
            flit_d.preamble.tail                        = (len_q == '0);
            flit_d.payload[0 +: kXyWidth]               = dest_q.x;
            flit_d.payload[OffLocal +: kXyWidth]        = LocalX.x;
            flit_d.payload[OffType +: $bits(message_t)] = type_q;
            flit_d.payload[OffLen +: LenW]              = len_q;
            state_d = (len_q == '0) ? StIdle : StBody;
          end
        end
        StBody: begin
          data_ready_o = credit_avail;
          if (data_valid_i && credit_avail) begin
            issue                = 1'b1;
            flit_d.preamble.head = 1'b0;
            flit_d.preamble.tail = (cnt_inc == len_q);
            flit_d.payload       = data_word_i;
            cnt_d                = cnt_inc;
            if (cnt_inc == len_q) begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM and per-message context registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      dest_q  <= '0;
      type_q  <= MsgReadReq;
      len_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= DirNone;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      type_q  <= type_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // Flit output stage: one-cycle valid pulse per issued flit, data held otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flit_valid_q <= 1'b0;
      flit_q       <= '0;
      flit_dir_q   <= DirNone;
    end else begin
      flit_valid_q <= issue;
      if (issue) begin
        flit_q     <= flit_d;
        flit_dir_q <= dir_q;
      end
    end
  end

  assign flit_valid_o = flit_valid_q;
  assign flit_data_o  = flit_q;
  assign flit_dir_o   = flit_dir_q;

endmodule

// File: tb/tb_noc_packetizer.sv
// Bench for noc_packetizer: directed scenarios plus randomized traffic
// compared against a message-level flit model.
module tb_noc_packetizer;
  import noc_pkg::*;

  localparam int FW     = 64;
  localparam int PW     = FW - 2;
  localparam int MaxLen = 4;
  localparam int NC     = 4;
  localparam int LW     = $clog2(MaxLen + 1);
  localparam int Lx     = 1;
  localparam xy_t kLocal = '{x: 2'd1};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          msg_valid = 1'b0;
  logic          msg_ready;
  xy_t           msg_dest = '0;
  message_t      msg_type = MsgReadReq;
  logic [LW-1:0] msg_len = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic [PW-1:0] data_word = '0;
  logic          flit_valid;
  logic [FW-1:0] flit_data;
  direction_t    flit_dir;
  logic          credit_in = 1'b0;

  always #5 clk = ~clk;

  noc_packetizer #(
    .FlitWidth   (FW),
    .MaxBodyFlits(MaxLen),
    .NumCredits  (NC),
    .LocalX      (kLocal)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .msg_valid_i (msg_valid),
    .msg_ready_o (msg_ready),
    .msg_dest_i  (msg_dest),
    .msg_type_i  (msg_type),
    .msg_len_i   (msg_len),
    .data_valid_i(data_valid),
    .data_ready_o(data_ready),
    .data_word_i (data_word),
    .flit_valid_o(flit_valid),
    .flit_data_o (flit_data),
    .flit_dir_o  (flit_dir),
    .credit_in_i (credit_in)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cred_model = NC;
  int in_flight = 0;
  bit hs_msg, hs_data;
  int hs_cyc;

  logic [FW-1:0] obs_data[$];
  logic [2:0]    obs_dir[$];
  int            obs_cyc[$];

  int            n_msgs, next_hdr, cur, wi;
  bit            have_cur;
  int            m_dest[64], m_type[64], m_len[64], m_acc[64];
  logic [PW-1:0] m_word[64][MaxLen];

  // ---------------- reference model ----------------
  function automatic logic [FW-1:0] exp_head(input int dest, input int typ, input int len);
    logic [PW-1:0] p;
    p = '0;
    p[1:0]      = 2'(dest);
    p[3:2]      = 2'(Lx);
    p[6:4]      = 3'(typ);
    p[7 +: LW]  = LW'(len);
    return {1'b1, (len == 0), p};
  endfunction

  function automatic logic [2:0] exp_dir(input int dest);
    int d;
    d = (dest - Lx + 4) % 4;
    if (d == 0) return 3'b001;
    if (d <= 2) return 3'b010;
    return 3'b100;
  endfunction

  function automatic int total_flits();
    int t = 0;
    for (int m = 0; m < n_msgs; m++) t += m_len[m] + 1;
    return t;
  endfunction

  // ---------------- stimulus plumbing ----------------
  // Called at posedge+1; samples handshakes late in the cycle, then the registered outputs.
  task automatic tick();
    bit cr;
    #7;
    hs_msg  = msg_valid && msg_ready;
    hs_data = data_valid && data_ready;
    hs_cyc  = cyc;
    cr      = credit_in;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      cred_model = NC;
      in_flight  = 0;
    end else begin
      if (cr && in_flight > 0) in_flight--;
      if (flit_valid) begin
        obs_data.push_back(flit_data);
        obs_dir.push_back(flit_dir);
        obs_cyc.push_back(cyc);
        in_flight++;
      end
      if (cr && !flit_valid && cred_model < NC) cred_model++;
      else if (!cr && flit_valid) cred_model--;
    end
  endtask

  task automatic clear_msgs();
    n_msgs = 0; next_hdr = 0; cur = 0; wi = 0; have_cur = 0;
    obs_data.delete(); obs_dir.delete(); obs_cyc.delete();
  endtask

  task automatic add_msg(input int dest, input int typ, input int len);
    m_dest[n_msgs] = dest;
    m_type[n_msgs] = typ;
    m_len[n_msgs]  = len;
    for (int k = 0; k < MaxLen; k++) m_word[n_msgs][k] = PW'({$urandom, $urandom});
    n_msgs++;
  endtask

  task automatic drive(input int ncyc, input int dv_pct, input int cr_pct,
                       input int stop_flits, input bit stop_done);
    for (int i = 0; i < ncyc; i++) begin
      msg_valid = (next_hdr < n_msgs);
      if (msg_valid) begin
        msg_dest = '{x: 2'(m_dest[next_hdr])};
        msg_type = message_t'(3'(m_type[next_hdr]));
        msg_len  = LW'(m_len[next_hdr]);
      end
      if (have_cur && wi < m_len[cur]) begin
        data_valid = ($urandom_range(99) < dv_pct);
        data_word  = m_word[cur][wi];
      end else begin
        data_valid = 1'b0;
        data_word  = PW'({$urandom, $urandom});
      end
      credit_in = (in_flight > 0) && ($urandom_range(99) < cr_pct);
      tick();
      if (hs_data) wi++;
      if (hs_msg) begin
        cur = next_hdr; m_acc[cur] = hs_cyc; next_hdr++; wi = 0; have_cur = 1;
      end
      if (stop_flits > 0 && obs_data.size() >= stop_flits) break;
      if (stop_done && next_hdr == n_msgs && (!have_cur || wi == m_len[cur]) &&
          obs_data.size() == total_flits()) break;
    end
    msg_valid = 1'b0; data_valid = 1'b0; credit_in = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && in_flight > 0; i++) begin
      credit_in = 1'b1;
      tick();
      credit_in = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (msg_ready !== 1'b0) begin errors++; $display("FAIL reset_msg_ready got %b want 0", msg_ready); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready got %b want 0", data_ready); end
    checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL reset_flit_valid got %b want 0", flit_valid); end
    checks++; if (flit_data !== '0) begin errors++; $display("FAIL reset_flit_data got %h want 0", flit_data); end
    checks++; if (flit_dir !== DirNone) begin errors++; $display("FAIL reset_flit_dir got %b want 000", flit_dir); end
    checks++; if (dut.u_credits.count_q !== 3'(NC)) begin errors++; $display("FAIL reset_credits got %0d want %0d", dut.u_credits.count_q, NC); end
    rst = 1'b0;
    #1;
    checks++; if (msg_ready !== 1'b1) begin errors++; $display("FAIL reset_release_msg_ready got %b want 1", msg_ready); end
  endtask

  task automatic test_route();
    int         dests[4] = '{1, 2, 3, 0};
    logic [2:0] want[4]  = '{3'b001, 3'b010, 3'b010, 3'b100};
    for (int i = 0; i < 4; i++) begin
      clear_msgs();
      add_msg(dests[i], $urandom_range(7), 0);
      drive(10, 100, 0, 0, 1);
      checks++;
      if (obs_data.size() != 1) begin
        errors++; $display("FAIL route_count dest %0d got %0d flits want 1", dests[i], obs_data.size());
      end else if (obs_dir[0] !== want[i] || obs_data[0] !== exp_head(dests[i], m_type[0], 0)) begin
        errors++; $display("FAIL route dest %0d got dir %b data %h want dir %b data %h", dests[i],
                           obs_dir[0], obs_data[0], want[i], exp_head(dests[i], m_type[0], 0));
      end
      drain();
    end
  endtask

  task automatic test_single_head();
    clear_msgs();
    checks++; if (dut.u_credits.count_q !== 3'd4) begin errors++; $display("FAIL single_credits_before got %0d want 4", dut.u_credits.count_q); end
    add_msg(2, 5, 0);
    drive(10, 100, 0, 0, 1);
    checks++;
    if (obs_data.size() != 1) begin
      errors++; $display("FAIL single_count got %0d want 1", obs_data.size());
    end else begin
      checks++; if (obs_data[0][FW-1 -: 2] !== 2'b11) begin errors++; $display("FAIL single_preamble got %b want 11", obs_data[0][FW-1 -: 2]); end
      checks++; if (obs_data[0] !== exp_head(2, 5, 0)) begin errors++; $display("FAIL single_data got %h want %h", obs_data[0], exp_head(2, 5, 0)); end
      checks++; if (obs_cyc[0] - m_acc[0] != 2) begin errors++; $display("FAIL single_latency got %0d want 2", obs_cyc[0] - m_acc[0]); end
      checks++; if (obs_dir[0] !== 3'b010) begin errors++; $display("FAIL single_dir got %b want 010", obs_dir[0]); end
    end
    checks++; if (dut.u_credits.count_q !== 3'd3) begin errors++; $display("FAIL single_credits_after got %0d want 3", dut.u_credits.count_q); end
    tick();
    checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle got %b want 0", flit_valid); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [1:0] want_pre[4] = '{2'b10, 2'b00, 2'b00, 2'b01};
    clear_msgs();
    add_msg(3, $urandom_range(7), 3);
    drive(20, 100, 0, 0, 1);
    checks++;
    if (obs_data.size() != 4) begin
      errors++; $display("FAIL b2b_count got %0d want 4", obs_data.size());
    end else begin
      checks++; if (obs_cyc[0] - m_acc[0] != 2) begin errors++; $display("FAIL b2b_latency got %0d want 2", obs_cyc[0] - m_acc[0]); end
      for (int i = 0; i < 4; i++) begin
        logic [FW-1:0] e;
        e = (i == 0) ? exp_head(3, m_type[0], 3) : {want_pre[i], m_word[0][i-1]};
        checks++;
        if (obs_data[i] !== e || obs_data[i][FW-1 -: 2] !== want_pre[i] || obs_cyc[i] != obs_cyc[0] + i) begin
          errors++; $display("FAIL b2b_flit %0d got %h @%0d want %h @%0d", i, obs_data[i], obs_cyc[i], e, obs_cyc[0] + i);
        end
      end
    end
    drain();
    // Two header-only messages offered continuously: one IDLE cycle between them.
    clear_msgs();
    add_msg(0, 1, 0);
    add_msg(2, 3, 0);
    drive(20, 100, 0, 0, 1);
    checks++;
    if (obs_data.size() != 2 || m_acc[1] - m_acc[0] != 2 || obs_cyc[1] - obs_cyc[0] != 2) begin
      errors++; $display("FAIL min_gap got flits %0d accept gap %0d want 2 flits gap 2",
                         obs_data.size(), m_acc[1] - m_acc[0]);
    end
    drain();
  endtask

  task automatic test_credit_stall();
    clear_msgs();
    add_msg(0, 6, 4);
    drive(15, 100, 0, 0, 0);
    data_valid = 1'b1;
    data_word  = m_word[0][3];
    #1;
    checks++; if (obs_data.size() != 4) begin errors++; $display("FAIL stall_count got %0d want 4", obs_data.size()); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL stall_data_ready got %b want 0", data_ready); end
    checks++; if (dut.u_credits.count_q !== 3'd0) begin errors++; $display("FAIL stall_credits got %0d want 0", dut.u_credits.count_q); end
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    repeat (4) tick();
    data_valid = 1'b0;
    checks++;
    if (obs_data.size() != 5) begin
      errors++; $display("FAIL stall_resume_count got %0d want 5", obs_data.size());
    end else if (obs_data[4] !== {2'b01, m_word[0][3]}) begin
      errors++; $display("FAIL stall_resume_tail got %h want %h", obs_data[4], {2'b01, m_word[0][3]});
    end
    drain();
  endtask

  task automatic test_credit_coincide();
    clear_msgs();
    add_msg(1, 0, 0); add_msg(2, 0, 0); add_msg(3, 0, 0);
    drive(20, 100, 0, 0, 1);
    checks++; if (dut.u_credits.count_q !== 3'd1) begin errors++; $display("FAIL coin_setup got %0d want 1", dut.u_credits.count_q); end
    clear_msgs();
    msg_valid = 1'b1; msg_dest = '{x: 2'd2}; msg_type = MsgReadResp; msg_len = '0;
    tick();
    msg_valid = 1'b0;
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    tick();
    checks++; if (obs_data.size() != 1) begin errors++; $display("FAIL coin_flit got %0d want 1", obs_data.size()); end
    checks++; if (dut.u_credits.count_q !== 3'd1) begin errors++; $display("FAIL coin_credits got %0d want 1", dut.u_credits.count_q); end
    drain();
    checks++; if (dut.u_credits.count_q !== 3'd4) begin errors++; $display("FAIL coin_refill got %0d want 4", dut.u_credits.count_q); end
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    checks++; if (dut.u_credits.count_q !== 3'd4) begin errors++; $display("FAIL coin_saturate got %0d want 4", dut.u_credits.count_q); end
  endtask

  task automatic test_reset_mid();
    clear_msgs();
    add_msg(3, 2, 3);
    drive(20, 100, 0, 2, 0);
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (obs_data.size() != 2) begin errors++; $display("FAIL rstmid_flits got %0d want 2", obs_data.size()); end
    checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", flit_valid); end
    checks++; if (dut.u_credits.count_q !== 3'd4) begin errors++; $display("FAIL rstmid_credits got %0d want 4", dut.u_credits.count_q); end
    rst = 1'b0;
    clear_msgs();
    add_msg(1, 4, 1);
    drive(15, 100, 0, 0, 1);
    checks++;
    if (obs_data.size() != 2) begin
      errors++; $display("FAIL rstmid_next_count got %0d want 2", obs_data.size());
    end else if (obs_data[0] !== exp_head(1, 4, 1) || obs_data[1] !== {2'b01, m_word[0][0]}) begin
      errors++; $display("FAIL rstmid_next got %h %h want %h %h", obs_data[0], obs_data[1],
                         exp_head(1, 4, 1), {2'b01, m_word[0][0]});
    end
    drain();
  endtask

  task automatic test_random();
    int k;
    clear_msgs();
    for (int m = 0; m < 25; m++) add_msg($urandom_range(3), $urandom_range(7), $urandom_range(MaxLen));
    drive(3000, 70, 50, 0, 1);
    checks++;
    if (next_hdr != n_msgs || obs_data.size() != total_flits()) begin
      errors++; $display("FAIL rand_progress got hdrs %0d flits %0d want %0d %0d",
                         next_hdr, obs_data.size(), n_msgs, total_flits());
    end
    checks++; if (dut.u_credits.count_q !== 3'(cred_model)) begin errors++; $display("FAIL rand_credits got %0d want %0d", dut.u_credits.count_q, cred_model); end
    k = 0;
    for (int m = 0; m < n_msgs; m++) begin
      for (int f = 0; f <= m_len[m]; f++) begin
        logic [FW-1:0] e;
        e = (f == 0) ? exp_head(m_dest[m], m_type[m], m_len[m]) : {1'b0, (f == m_len[m]), m_word[m][f-1]};
        if (k < obs_data.size()) begin
          checks++;
          if (obs_data[k] !== e || obs_dir[k] !== exp_dir(m_dest[m])) begin
            errors++; $display("FAIL rand_flit msg %0d flit %0d got %h dir %b want %h dir %b",
                               m, f, obs_data[k], obs_dir[k], e, exp_dir(m_dest[m]));
          end
        end
        k++;
      end
    end
    drain();
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_route();
    test_single_head();
    test_back_to_back();
    test_credit_stall();
    test_credit_coincide();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
